// File: rtl/alu_execute_unit_if.sv
// Operand/result bundle between the register-file read side and the ALU execute stage.
// Latency: none; this is wiring only.
// Backpressure: none; start is honoured only when the execute stage is idle, otherwise it is dropped.
interface alu_execute_unit_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 4
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [SEL_W-1:0] dest_sel;
    logic             busy;
    logic             done;
    logic             wr_en;
    logic [WIDTH-1:0] result;
    logic [SEL_W-1:0] result_sel;
    logic             carry;
    logic             zero;

    // Request side: issues operations and consumes write-back results.
    modport master (
        output start, op, A, B, dest_sel,
        input  busy, done, wr_en, result, result_sel, carry, zero
    );

    // Execute side.
    modport slave (
        input  start, op, A, B, dest_sel,
        output busy, done, wr_en, result, result_sel, carry, zero
    );
endinterface

// File: rtl/alu_execute_unit.sv
// ALU execute stage: 8 ops on captured operands, write-back strobe to the register file.
// Latency: done follows the accept edge by 1 cycle (ADD/SUB/logic/PASS), WIDTH cycles (MUL) or max(shamt,1) cycles (SHL).
// Backpressure: one op in flight; start arriving while busy is dropped, not queued.
module alu_execute_unit #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    alu_execute_unit_if.slave bus
);

    // Counter must cover both the MUL iteration count and the 3-bit shift amount.
    localparam int CNT_W = ($clog2(WIDTH) > 3) ? $clog2(WIDTH) : 3;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Operands captured at accept; later changes on the inputs are ignored.
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [SEL_W-1:0]   sel_q;
    logic [CNT_W-1:0]   cnt;

    // Iterative datapath: mcand shifts left (MUL multiplicand / SHL shifter),
    // mplier shifts right exposing one multiplier bit per cycle.
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] prod_q;

    // Write-back registers, held until the next completion.
    logic [WIDTH-1:0]   result_q;
    logic [SEL_W-1:0]   result_sel_q;
    logic               carry_q;
    logic               zero_q;

    logic [2:0]         shamt;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic [2*WIDTH-1:0] prod_next;
    logic               exec_last;
    logic [WIDTH-1:0]   res_next;
    logic               carry_next;

    assign shamt     = b_q[2:0];
    assign sum_ext   = {1'b0, a_q} + {1'b0, b_q};
    assign diff_ext  = {1'b0, a_q} - {1'b0, b_q};
    assign prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);

    // Decide whether the current EXEC cycle is the final iteration for this op.
    always_comb begin
        exec_last = 1'b1;
        case (op_q)
            OP_MUL:  exec_last = (cnt == CNT_W'(WIDTH - 1));
            OP_SHL:  exec_last = (shamt == 3'd0) || (cnt == (CNT_W'(shamt) - CNT_W'(1)));
            default: exec_last = 1'b1;
        endcase
    end

    // Result and carry as they will be registered on the final EXEC edge.
    always_comb begin
        res_next   = '0;
        carry_next = 1'b0;
        case (op_q)
            OP_ADD: begin
                res_next   = sum_ext[WIDTH-1:0];
                carry_next = sum_ext[WIDTH];
            end
            OP_SUB: begin
                res_next   = diff_ext[WIDTH-1:0];
                carry_next = diff_ext[WIDTH];
            end
            OP_AND:  res_next = a_q & b_q;
            OP_OR:   res_next = a_q | b_q;
            OP_XOR:  res_next = a_q ^ b_q;
            OP_SHL: begin
                if (shamt == 3'd0) begin
                    res_next = a_q;
                end else begin
                    // mcand already holds A shifted by cnt; this cycle does the last shift.
                    res_next   = {mcand_q[WIDTH-2:0], 1'b0};
                    carry_next = mcand_q[WIDTH-1];
                end
            end
            OP_MUL: begin
                res_next   = prod_next[WIDTH-1:0];
                carry_next = |prod_next[2*WIDTH-1:WIDTH];
            end
            OP_PASS: res_next = a_q;
            default: res_next = a_q;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: accept only in IDLE, leave DONE after exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = EXEC;
            EXEC:    if (exec_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, per-cycle iteration and write-back register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= '0;
            cnt          <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            prod_q       <= '0;
            result_q     <= '0;
            result_sel_q <= '0;
            carry_q      <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q     <= bus.op;
                        a_q      <= bus.A;
                        b_q      <= bus.B;
                        sel_q    <= bus.dest_sel;
                        cnt      <= '0;
                        mcand_q  <= {{WIDTH{1'b0}}, bus.A};
                        mplier_q <= bus.B;
                        prod_q   <= '0;
                    end
                end
                EXEC: begin
                    cnt      <= cnt + CNT_W'(1);
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    prod_q   <= prod_next;
                    if (exec_last) begin
                        result_q     <= res_next;
                        carry_q      <= carry_next;
                        zero_q       <= (res_next == '0);
                        result_sel_q <= sel_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);
    assign bus.wr_en      = (state == DONE);
    assign bus.result     = result_q;
    assign bus.result_sel = result_sel_q;
    assign bus.carry      = carry_q;
    assign bus.zero       = zero_q;

endmodule
